// File: rtl/sc_tick_sequencer.sv
// Step sequencer paced by an external timebase counter's end-of-count.
// Optional step counter output is enabled with the macro SC_TICK_STEPCOUNT_EN.
module sc_tick_sequencer #(
  parameter int POSITION_DATAWIDTH_BUS = 4,
  parameter int POSITION_MAX           = 12
) (
  input  logic                              SC_COUNTER_CLOCK_50,
  input  logic                              SC_COUNTER_RESET_InLow,
  input  logic                              SC_TICK_eoc_InLow,
  input  logic                              SC_TICK_enable_InLow,
  input  logic [3:0]                        SC_TICK_speed_InBUS,
  output logic                              SC_TICK_clear_Out,
  output logic                              SC_TICK_step_OutLow,
  output logic [POSITION_DATAWIDTH_BUS-1:0] SC_TICK_position_OutBUS,
  output logic                              SC_TICK_direction_Out
`ifdef SC_TICK_STEPCOUNT_EN
  ,
  output logic [7:0]                        SC_TICK_stepcount_OutBUS
`endif
);

  localparam logic [POSITION_DATAWIDTH_BUS-1:0] POS_MAX = POSITION_DATAWIDTH_BUS'(POSITION_MAX);
  localparam logic [POSITION_DATAWIDTH_BUS-1:0] POS_ONE = POSITION_DATAWIDTH_BUS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2,
    STEP  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]                        prescale;
  logic [3:0]                        eff_speed;
  logic                              step_due;
  logic [POSITION_DATAWIDTH_BUS-1:0] position;
  logic                              direction;

  // A speed of 0 behaves as 1 so the sequencer can never stall in CLEAR/RUN.
  always_comb begin
    eff_speed = (SC_TICK_speed_InBUS == 4'd0) ? 4'd1 : SC_TICK_speed_InBUS;
    step_due  = (({1'b0, prescale} + 5'd1) >= {1'b0, eff_speed});
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (SC_TICK_enable_InLow) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = RUN;
        RUN:     if (!SC_TICK_eoc_InLow) next_state = CLEAR;
        CLEAR:   next_state = step_due ? STEP : RUN;
        STEP:    next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // Disabling freezes prescale, position and direction so a resume picks up where it left off.
  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      prescale  <= 4'd0;
      position  <= '0;
      direction <= 1'b0;
    end else if (!SC_TICK_enable_InLow) begin
      if (state == CLEAR) begin
        prescale <= step_due ? 4'd0 : prescale + 4'd1;
      end
      if (state == STEP) begin
        if (!direction) begin
          if (position < POS_MAX) begin
            position <= position + POS_ONE;
          end else begin
            direction <= 1'b1;
            position  <= position - POS_ONE;
          end
        end else begin
          if (position != '0) begin
            position <= position - POS_ONE;
          end else begin
            direction <= 1'b0;
            position  <= position + POS_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    SC_TICK_clear_Out       = (state == IDLE) || (state == CLEAR);
    SC_TICK_step_OutLow     = (state != STEP);
    SC_TICK_position_OutBUS = position;
    SC_TICK_direction_Out   = direction;
  end

`ifdef SC_TICK_STEPCOUNT_EN
  logic [7:0] stepcount;

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      stepcount <= 8'd0;
    end else if ((state == STEP) && (stepcount != 8'hFF)) begin
      stepcount <= stepcount + 8'd1;
    end
  end

  assign SC_TICK_stepcount_OutBUS = stepcount;
`endif

endmodule
